// File: rtl/ecc_pkg.sv
// ecc_pkg
//   Shared constants and types for the NB-LDPC ECC write-back path.
//   FIELD       : bits per GF(2^FIELD) symbol
//   PARALLEL    : lanes per write-back beat (INFO_GROUP info + 2 check)
//   INFO_GROUP  : info symbols carried per beat
//   PERIOD      : beats per codeword (array rows)
//   SYMBOL_NUM  : symbols per codeword
//   INFO_NUM    : info symbols per codeword (PERIOD*INFO_GROUP)
//   COUNTER_BIT : beat counter width
package ecc_pkg;

    localparam int FIELD       = 3;
    localparam int PARALLEL    = 10;
    localparam int INFO_GROUP  = 8;
    localparam int PERIOD      = 32;
    localparam int SYMBOL_NUM  = 288;
    localparam int INFO_NUM    = 256;
    localparam int COUNTER_BIT = 5;

    // Populated lanes: info lanes plus the differential check pair.
    localparam int LANES     = INFO_GROUP + 2;
    localparam int SHADOW_W  = SYMBOL_NUM * FIELD;
    localparam int BEAT_W    = PARALLEL * FIELD;
    localparam int SYM_IDX_W = $clog2(SYMBOL_NUM);

    typedef logic [FIELD-1:0] symbol_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/ecc_writeback_serializer_beat_mux.sv
// beat_mux
//   Purely combinational lane selector. For beat (row) e it places info
//   symbols e*INFO_GROUP .. e*INFO_GROUP+INFO_GROUP-1 on lanes 0..INFO_GROUP-1,
//   check symbol INFO_NUM+e on lane INFO_GROUP and its bitwise complement on
//   lane INFO_GROUP+1. Bits above the populated lanes are zero.
//   i_shadow : latched codeword, symbol s at [s*FIELD +: FIELD]
//   i_row    : beat index
//   o_beat   : beat data, lane l at [l*FIELD +: FIELD]
module beat_mux
    import ecc_pkg::*;
(
    input  logic [SHADOW_W-1:0]    i_shadow,
    input  logic [COUNTER_BIT-1:0] i_row,
    output logic [BEAT_W-1:0]      o_beat
);

    // Packed views: element s of w_sym is exactly bits [s*FIELD +: FIELD].
    symbol_t [SYMBOL_NUM-1:0] w_sym;
    symbol_t [LANES-1:0]      w_lanes;
    logic [SYM_IDX_W-1:0]     w_base;
    logic [SYM_IDX_W-1:0]     w_chk_idx;
    symbol_t                  w_chk;

    assign w_sym     = i_shadow;
    assign w_base    = SYM_IDX_W'(i_row) * SYM_IDX_W'(INFO_GROUP);
    assign w_chk_idx = SYM_IDX_W'(INFO_NUM) + SYM_IDX_W'(i_row);
    assign w_chk     = w_sym[w_chk_idx];

    for (genvar g = 0; g < INFO_GROUP; g++) begin : g_info
        assign w_lanes[g] = w_sym[w_base + SYM_IDX_W'(g)];
    end

    // Differential check pair: true and complemented copy of the check symbol.
    assign w_lanes[INFO_GROUP]   = w_chk;
    assign w_lanes[INFO_GROUP+1] = ~w_chk;

    // Zero-extends when the beat is wider than the populated lanes.
    assign o_beat = BEAT_W'(w_lanes);

endmodule

// File: rtl/ecc_writeback_serializer.sv
// ecc_writeback_serializer
//   Accepts one decoded codeword in a single transfer and streams it to the
//   CIM array write drivers as PERIOD beats of PARALLEL lanes. Codewords the
//   decoder failed to correct are never written; they finish with WB_ERR.
//   ADC_CLK        : clock
//   SYS_RST        : asynchronous active-high reset
//   CE             : clock enable, all state holds while low
//   DEC_SYMBOL_OUT : decoded codeword, DEC_VALID/DEC_READY handshake
//   DEC_SUCCESS    : decoder converged, sampled with DEC_VALID
//   WB_DATA/WB_ROW : beat data and row index, WB_VALID/WB_READY handshake
//   WB_LAST        : current beat is the last row
//   WB_DONE/WB_ERR : one-cycle completion pulse and its reject flag
module ecc_writeback_serializer
    import ecc_pkg::*;
(
    input  logic                   ADC_CLK,
    input  logic                   SYS_RST,
    input  logic                   CE,
    input  logic [SHADOW_W-1:0]    DEC_SYMBOL_OUT,
    input  logic                   DEC_VALID,
    input  logic                   DEC_SUCCESS,
    output logic                   DEC_READY,
    output logic [BEAT_W-1:0]      WB_DATA,
    output logic [COUNTER_BIT-1:0] WB_ROW,
    output logic                   WB_VALID,
    input  logic                   WB_READY,
    output logic                   WB_LAST,
    output logic                   WB_DONE,
    output logic                   WB_ERR
);

    state_e                 r_state;
    state_e                 w_next_state;
    logic [COUNTER_BIT-1:0] r_count;
    logic                   r_err;
    logic [SHADOW_W-1:0]    r_shadow;
    logic [BEAT_W-1:0]      w_beat;
    logic                   w_last;

    assign w_last = (r_count == COUNTER_BIT'(PERIOD - 1));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge ADC_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            r_state <= IDLE;
        end else if (CE) begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. CE is applied at the registers, so a handshake seen
    // here with CE low never takes effect.
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and a latch cannot be inferred.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (DEC_VALID) w_next_state = DEC_SUCCESS ? SEND : FIN;
            SEND:    if (WB_READY && w_last) w_next_state = FIN;
            FIN:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath registers: shadow codeword, beat counter and reject flag.
    // The shadow only loads in IDLE, so DEC_VALID during SEND/FIN cannot
    // corrupt a codeword that is still being written.
    // NOTE: the wide shadow register is reset explicitly so WB_DATA and the
    // check lanes are deterministic after reset; it is flops, not a RAM.
    always_ff @(posedge ADC_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            r_count  <= '0;
            r_err    <= 1'b0;
            r_shadow <= '0;
        end else if (CE) begin
            unique case (r_state)
                IDLE: begin
                    if (DEC_VALID) begin
                        r_shadow <= DEC_SYMBOL_OUT;
                        r_err    <= ~DEC_SUCCESS;
                        r_count  <= '0;
                    end
                end
                SEND: begin
                    // Hold at the last row instead of wrapping to 0.
                    if (WB_READY && !w_last) begin
                        r_count <= r_count + COUNTER_BIT'(1);
                    end
                end
                FIN: begin
                    r_count <= '0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_count <= '0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    beat_mux u_beat_mux (
        .i_shadow (r_shadow),
        .i_row    (r_count),
        .o_beat   (w_beat)
    );

    // Output decode. Everything derives from registers, so outputs hold
    // whenever CE freezes the state.
    always_comb begin
        DEC_READY = 1'b0;
        WB_VALID  = 1'b0;
        WB_LAST   = 1'b0;
        WB_DONE   = 1'b0;
        WB_ERR    = 1'b0;
        WB_DATA   = '0;
        WB_ROW    = r_count;
        unique case (r_state)
            IDLE: DEC_READY = 1'b1;
            SEND: begin
                WB_VALID = 1'b1;
                WB_LAST  = w_last;
                WB_DATA  = w_beat;
            end
            FIN: begin
                WB_DONE = 1'b1;
                WB_ERR  = r_err;
            end
            default: DEC_READY = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ecc_writeback_serializer.sv
module tb_ecc_writeback_serializer;
    import ecc_pkg::*;

    typedef symbol_t [SYMBOL_NUM-1:0] cw_t;
    typedef logic [BEAT_W-1:0] beat_t;

    typedef struct {
        int      row;
        symbol_t chk;
        logic    last;
    } vec_t;

    logic                   ADC_CLK = 1'b0;
    logic                   SYS_RST;
    logic                   CE;
    cw_t                    DEC_SYMBOL_OUT;
    logic                   DEC_VALID;
    logic                   DEC_SUCCESS;
    logic                   DEC_READY;
    logic [BEAT_W-1:0]      WB_DATA;
    logic [COUNTER_BIT-1:0] WB_ROW;
    logic                   WB_VALID;
    logic                   WB_READY;
    logic                   WB_LAST;
    logic                   WB_DONE;
    logic                   WB_ERR;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t got_beat [PERIOD];
    logic  got_last [PERIOD];
    int    done_cyc;

    ecc_writeback_serializer dut (
        .ADC_CLK        (ADC_CLK),
        .SYS_RST        (SYS_RST),
        .CE             (CE),
        .DEC_SYMBOL_OUT (DEC_SYMBOL_OUT),
        .DEC_VALID      (DEC_VALID),
        .DEC_SUCCESS    (DEC_SUCCESS),
        .DEC_READY      (DEC_READY),
        .WB_DATA        (WB_DATA),
        .WB_ROW         (WB_ROW),
        .WB_VALID       (WB_VALID),
        .WB_READY       (WB_READY),
        .WB_LAST        (WB_LAST),
        .WB_DONE        (WB_DONE),
        .WB_ERR         (WB_ERR)
    );

    always #5 ADC_CLK = ~ADC_CLK;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference beat: gather lanes from the codeword by the lane rules, then
    // pack them by shifting.
    function automatic beat_t model_beat(input cw_t cw, input int e);
        symbol_t lanes [LANES];
        symbol_t chk;
        beat_t   b;
        for (int g = 0; g < INFO_GROUP; g++) lanes[g] = cw[SYM_IDX_W'(e * INFO_GROUP + g)];
        chk = cw[SYM_IDX_W'(INFO_NUM + e)];
        lanes[INFO_GROUP]     = chk;
        lanes[INFO_GROUP + 1] = ~chk;
        b = '0;
        for (int l = 0; l < LANES; l++) b = b | (beat_t'(lanes[l]) << (l * FIELD));
        return b;
    endfunction

    // Hand-written beat for the s mod 8 codeword: info lanes are 7..0.
    function automatic beat_t mk_beat(input symbol_t chk);
        return {~chk, chk, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    endfunction

    function automatic cw_t rand_cw();
        cw_t cw;
        for (int s = 0; s < SYMBOL_NUM; s++) cw[SYM_IDX_W'(s)] = symbol_t'($urandom);
        return cw;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " dec_ready"}, 64'(DEC_READY), 64'(1));
        check({tag, " wb_valid"},  64'(WB_VALID),  64'(0));
        check({tag, " wb_data"},   64'(WB_DATA),   64'(0));
        check({tag, " wb_row"},    64'(WB_ROW),    64'(0));
        check({tag, " wb_last"},   64'(WB_LAST),   64'(0));
        check({tag, " wb_done"},   64'(WB_DONE),   64'(0));
        check({tag, " wb_err"},    64'(WB_ERR),    64'(0));
    endtask

    // Send one codeword and follow it to WB_DONE. Called at a negedge with
    // the DUT idle. rdy_mode: 0 always ready, 1 random, 2 stall two cycles on
    // row 5. ce_mode: 0 always on, 1 random, 2 off three cycles on row 12.
    task automatic run_cw(input cw_t cw, input logic succ, input int rdy_mode,
                          input int ce_mode, input logic inject, input string tag);
        int   exp_row = 0;
        int   stall   = 0;
        int   ce_off  = 0;
        logic done    = 1'b0;
        logic rdy;
        logic ce;
        logic mvalid;

        check({tag, " accept ready"}, 64'(DEC_READY), 64'(1));
        DEC_SYMBOL_OUT = cw;
        DEC_SUCCESS    = succ;
        DEC_VALID      = 1'b1;
        CE             = 1'b1;
        WB_READY       = 1'b1;
        @(negedge ADC_CLK);
        DEC_VALID      = 1'b0;
        DEC_SYMBOL_OUT = ~cw;
        done_cyc       = -1;

        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            mvalid = succ && (exp_row < PERIOD);
            if (!mvalid) begin
                check({tag, " done"},      64'(WB_DONE),   64'(1));
                check({tag, " err"},       64'(WB_ERR),    64'(!succ));
                check({tag, " fin valid"}, 64'(WB_VALID),  64'(0));
                check({tag, " fin ready"}, 64'(DEC_READY), 64'(0));
                check({tag, " beats"},     64'(exp_row),   64'(succ ? PERIOD : 0));
                done      = 1'b1;
                done_cyc  = cyc;
                CE        = 1'b1;
                WB_READY  = 1'b1;
                DEC_VALID = 1'b0;
                @(negedge ADC_CLK);
                check({tag, " done pulse"}, 64'(WB_DONE),   64'(0));
                check({tag, " idle ready"}, 64'(DEC_READY), 64'(1));
            end else begin
                check({tag, " valid"}, 64'(WB_VALID),  64'(1));
                check({tag, " busy"},  64'(DEC_READY), 64'(0));
                check({tag, " early done"}, 64'(WB_DONE), 64'(0));
                check({tag, " row"},   64'(WB_ROW),    64'(exp_row));
                check({tag, " data"},  64'(WB_DATA),   64'(model_beat(cw, exp_row)));
                check({tag, " last"},  64'(WB_LAST),   64'(exp_row == PERIOD - 1));

                case (rdy_mode)
                    1:       rdy = 1'($urandom_range(0, 1));
                    2: begin
                        rdy = !(exp_row == 5 && stall < 2);
                        if (!rdy) stall++;
                    end
                    default: rdy = 1'b1;
                endcase
                case (ce_mode)
                    1:       ce = ($urandom_range(0, 3) != 0);
                    2: begin
                        ce = !(exp_row == 12 && ce_off < 3);
                        if (!ce) ce_off++;
                    end
                    default: ce = 1'b1;
                endcase
                if (inject && exp_row >= 3 && exp_row <= 6) begin
                    DEC_VALID      = 1'b1;
                    DEC_SUCCESS    = 1'($urandom_range(0, 1));
                    DEC_SYMBOL_OUT = rand_cw();
                end else begin
                    DEC_VALID = 1'b0;
                end
                if (rdy && ce) begin
                    got_beat[exp_row] = WB_DATA;
                    got_last[exp_row] = WB_LAST;
                    exp_row++;
                end
                WB_READY = rdy;
                CE       = ce;
                @(negedge ADC_CLK);
            end
        end
        if (!done) check({tag, " timeout"}, 64'(0), 64'(1));
        DEC_VALID = 1'b0;
        CE        = 1'b1;
    endtask

    initial begin
        vec_t tbl [7];
        cw_t  cw;
        logic found;

        tbl[0] = '{row: 0,  chk: 3'd0, last: 1'b0};
        tbl[1] = '{row: 1,  chk: 3'd1, last: 1'b0};
        tbl[2] = '{row: 5,  chk: 3'd5, last: 1'b0};
        tbl[3] = '{row: 7,  chk: 3'd7, last: 1'b0};
        tbl[4] = '{row: 8,  chk: 3'd0, last: 1'b0};
        tbl[5] = '{row: 30, chk: 3'd6, last: 1'b0};
        tbl[6] = '{row: 31, chk: 3'd7, last: 1'b1};

        SYS_RST        = 1'b1;
        CE             = 1'b0;
        DEC_VALID      = 1'b0;
        DEC_SUCCESS    = 1'b0;
        DEC_SYMBOL_OUT = '0;
        WB_READY       = 1'b0;
        #1;
        check_reset_outputs("por");
        @(negedge ADC_CLK);
        @(negedge ADC_CLK);
        SYS_RST = 1'b0;
        CE      = 1'b1;
        @(negedge ADC_CLK);
        check_reset_outputs("idle");

        // Full write of the s mod 8 codeword, checked against the table.
        for (int s = 0; s < SYMBOL_NUM; s++) cw[SYM_IDX_W'(s)] = symbol_t'(s % 8);
        run_cw(cw, 1'b1, 0, 0, 1'b0, "full");
        check("full done latency", 64'(done_cyc), 64'(PERIOD));
        for (int i = 0; i < 7; i++) begin
            check($sformatf("table data row%0d", tbl[i].row),
                  64'(got_beat[tbl[i].row]), 64'(mk_beat(tbl[i].chk)));
            check($sformatf("table last row%0d", tbl[i].row),
                  64'(got_last[tbl[i].row]), 64'(tbl[i].last));
        end

        run_cw(rand_cw(), 1'b1, 2, 0, 1'b0, "backpressure");
        check("backpressure latency", 64'(done_cyc), 64'(PERIOD + 2));

        run_cw(rand_cw(), 1'b0, 0, 0, 1'b0, "decfail");
        check("decfail latency", 64'(done_cyc), 64'(0));

        run_cw(rand_cw(), 1'b1, 0, 2, 1'b1, "ce_inject");
        check("ce_inject latency", 64'(done_cyc), 64'(PERIOD + 3));

        // Reset mid-SEND at row 10.
        cw = rand_cw();
        DEC_SYMBOL_OUT = cw;
        DEC_SUCCESS    = 1'b1;
        DEC_VALID      = 1'b1;
        WB_READY       = 1'b1;
        @(negedge ADC_CLK);
        DEC_VALID = 1'b0;
        found     = 1'b0;
        for (int c = 0; c < 64 && !found; c++) begin
            if (WB_ROW == COUNTER_BIT'(10) && WB_VALID) found = 1'b1;
            else @(negedge ADC_CLK);
        end
        check("rst reach row10", 64'(found), 64'(1));
        SYS_RST = 1'b1;
        #1;
        check_reset_outputs("rst mid");
        @(negedge ADC_CLK);
        SYS_RST = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge ADC_CLK);
            check("rst no done", 64'(WB_DONE), 64'(0));
        end
        run_cw(rand_cw(), 1'b1, 0, 0, 1'b0, "after_rst");

        // Randomized codewords, readiness, enables and stray DEC_VALID.
        for (int t = 0; t < 6; t++) begin
            run_cw(rand_cw(), ($urandom_range(0, 4) != 0), 1, 1,
                   1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ecc_writeback_serializer.md
Name: ecc_writeback_serializer

Overview:
- Write-back side of the NB-LDPC ECC path; takes the opposite direction to the ADC input buffer.
- Accepts one decoded codeword (SYMBOL_NUM GF(2^FIELD) symbols) from the decoder in a single transfer.
- Streams the codeword back to the CIM array write drivers as PERIOD row beats of PARALLEL lanes, in the same column order the input buffer gathers it.
- Uncorrectable codewords are never written back; they are reported as an error.

Parameters:
- PARALLEL, 10, lanes per beat (INFO_GROUP info lanes + 2 check lanes)
- INFO_GROUP, 8, info symbols per beat
- FIELD, 3, bits per GF symbol
- SYMBOL_NUM, 288, symbols per codeword
- INFO_NUM, 256, info symbols per codeword (= PERIOD*INFO_GROUP)
- PERIOD, 32, beats per codeword
- COUNTER_BIT, 5, beat counter width (2^COUNTER_BIT >= PERIOD)

Ports:
- ADC_CLK  input  1  block clock
- SYS_RST  input  1  asynchronous active-high reset
- CE  input  1  clock enable; when low, all state holds and the outputs hold
- DEC_SYMBOL_OUT  input  SYMBOL_NUM*FIELD  decoded symbols; symbol s occupies bits [s*FIELD +: FIELD]
- DEC_VALID  input  1  decoded codeword present
- DEC_SUCCESS  input  1  decoder converged (sampled together with DEC_VALID)
- DEC_READY  output  1  serializer can accept a codeword
- WB_DATA  output  PARALLEL*FIELD  beat data; lane l occupies bits [l*FIELD +: FIELD]
- WB_ROW  output  COUNTER_BIT  beat index (array row) of WB_DATA
- WB_VALID  output  1  WB_DATA and WB_ROW valid
- WB_READY  input  1  write driver accepts the beat
- WB_LAST  output  1  current beat is beat PERIOD-1
- WB_DONE  output  1  one-cycle pulse; codeword fully written or rejected
- WB_ERR  output  1  qualified by WB_DONE; 1 = rejected, nothing written

Behaviour:
- Clock and reset: single clock ADC_CLK. SYS_RST is asynchronous and active-high.
- Reset values:
  - State = IDLE, counter = 0.
  - DEC_READY = 1.
  - WB_VALID = 0, WB_LAST = 0, WB_DONE = 0, WB_ERR = 0.
  - WB_DATA = 0, WB_ROW = 0.
  - Shadow register = 0.
- All sequential updates are gated by CE. When CE = 0, state freezes and no handshake completes, even if VALID and READY are both high.
- FSM states: IDLE, SEND, FIN.
- IDLE:
  - DEC_READY = 1.
  - On DEC_VALID (CE high), latch DEC_SYMBOL_OUT into the SYMBOL_NUM*FIELD shadow register and latch DEC_SUCCESS.
  - If DEC_SUCCESS = 1: go to SEND with counter = 0.
  - If DEC_SUCCESS = 0: go to FIN with the error flag set.
- SEND:
  - DEC_READY = 0 and WB_VALID = 1.
  - The first beat appears the cycle after acceptance (latency 1).
- Lane mapping for beat e:
  - Lane g < INFO_GROUP carries shadow symbol e*INFO_GROUP+g.
  - Lane INFO_GROUP carries check symbol INFO_NUM+e.
  - Lane INFO_GROUP+1 carries the bitwise complement of that check symbol (differential check pair).
- WB_ROW = e. WB_LAST = (e == PERIOD-1).
- Beat handshake:
  - A beat transfers when WB_VALID & WB_READY & CE.
  - On transfer the counter increments. On transfer with WB_LAST, go to FIN.
  - While WB_READY = 0, WB_DATA and WB_ROW hold stable. The counter never wraps within a codeword.
- FIN:
  - Lasts exactly one cycle, with WB_DONE = 1, WB_ERR = error flag, WB_VALID = 0 and DEC_READY = 0.
  - Then return to IDLE, clearing the flag and the counter.
- Back-to-back: a new codeword is accepted no earlier than the IDLE cycle after FIN. Minimum period is PERIOD+2 cycles with WB_READY held high.
- DEC_VALID outside IDLE is ignored, and the shadow register is not overwritten.
- Reset mid-SEND: abort immediately to reset values; the partial codeword is discarded and no WB_DONE is produced.
- Zero-padding: if FIELD*PARALLEL output width exceeds the populated lanes, the unused bits are 0.

Decomposition:
- Shared package ecc_pkg: FIELD, PARALLEL, INFO_GROUP, PERIOD, SYMBOL_NUM, INFO_NUM, COUNTER_BIT; a symbol typedef logic [FIELD-1:0]; an FSM state enum {IDLE, SEND, FIN}.
- One natural sub-module, beat_mux: purely combinational; takes the shadow register and the counter and produces the PARALLEL-lane beat, including the check-lane complement.

Test Plan:
- Reset then idle: assert SYS_RST async mid-cycle -> DEC_READY = 1, WB_VALID = 0, WB_DATA = 0, all outputs at reset values before the next edge.
- Full write, WB_READY = 1:
  - Stimulus: symbol s = s mod 8, DEC_SUCCESS = 1.
  - Expected: 32 consecutive beats, WB_ROW 0..31.
  - Beat 0 lanes 0..7 = 0..7; lane 8 = symbol 256 = 0; lane 9 = 3'b111.
  - WB_LAST only on row 31; WB_DONE = 1 with WB_ERR = 0 one cycle later.
- Backpressure: toggle WB_READY 1,0,0,1 during row 5 -> WB_DATA and WB_ROW held at 5 through the stall; no row is skipped or duplicated; total accepted beats = 32.
- Decode failure: DEC_VALID with DEC_SUCCESS = 0 -> WB_VALID never asserts; WB_DONE = 1 and WB_ERR = 1 the next cycle; DEC_READY = 1 the cycle after.
- CE gating and ignore rule:
  - Drop CE for 3 cycles mid-SEND -> no state, counter or data change during those cycles.
  - Pulse DEC_VALID with a new codeword during SEND -> beats still match the original codeword.
- Reset mid-SEND at row 10: assert SYS_RST -> no WB_DONE; a fresh codeword afterwards restarts at row 0 with the correct data.
